// File: rtl/pulse_param_rx_if.sv
// Pulse parameter receiver bus: UART line in,
// full pulse-programming parameter set and strobes out.
interface pulse_param_rx_if;
  logic        rxd;
  logic [7:0]  per;
  logic [15:0] p1wid;
  logic [15:0] del;
  logic [15:0] p2wid;
  logic [31:0] nut_w;
  logic [31:0] nut_d;
  logic [7:0]  cp;
  logic [7:0]  p_bl;
  logic [15:0] p_bl_off;
  logic        pu;
  logic        bl;
  logic        nut;
  logic        rx_done;
  logic        rx_err;

  modport master (
    input  rxd,
    output per, p1wid, del, p2wid,
    output nut_w, nut_d, cp, p_bl,
    output p_bl_off, pu, bl, nut,
    output rx_done, rx_err
  );

  modport slave (
    output rxd,
    input  per, p1wid, del, p2wid,
    input  nut_w, nut_d, cp, p_bl,
    input  p_bl_off, pu, bl, nut,
    input  rx_done, rx_err
  );
endinterface

// File: rtl/pulse_param_rx.sv
// 8N1 UART packet receiver: sync + 20 payload bytes + checksum,
// applies the pulse parameter set atomically on a good packet.
module pulse_param_rx #(
  parameter int          CLKS_PER_BIT = 1745,
  parameter int          TIMEOUT_CLKS = 200000,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
  input  logic            clk_pll,
  input  logic            reset,
  pulse_param_rx_if.master bus
);
  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [31:0] TMO = 32'(TIMEOUT_CLKS);

  localparam logic [1:0] B_IDLE  = 2'd0;
  localparam logic [1:0] B_START = 2'd1;
  localparam logic [1:0] B_DATA  = 2'd2;
  localparam logic [1:0] B_STOP  = 2'd3;

  localparam logic [1:0] P_HUNT = 2'd0;
  localparam logic [1:0] P_PAY  = 2'd1;
  localparam logic [1:0] P_CHK  = 2'd2;

  localparam logic [154:0] DEF = {
    8'd1, 16'd30, 16'd200, 16'd30,
    32'd50, 32'd300,
    8'd3, 8'd50, 16'd100, 3'b111
  };

  logic [2:0]    sync_q, sync_d;
  logic [1:0]    bst_q, bst_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bidx_q, bidx_d;
  logic [7:0]    sh_q, sh_d;
  logic [7:0]    rbyte_q, rbyte_d;
  logic          bv_q, bv_d;
  logic          fb_q, fb_d;

  logic [1:0]    pst_q, pst_d;
  logic [4:0]    idx_q, idx_d;
  logic [7:0]    sum_q, sum_d;
  logic [151:0]  shadow_q, shadow_d;
  logic [2:0]    flags_q, flags_d;
  logic [31:0]   tim_q, tim_d;
  logic [154:0]  params_q, params_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  logic rx_s;
  logic fall;
  logic timeout;

  assign rx_s    = sync_q[1];
  assign fall    = sync_q[2] & ~sync_q[1];
  assign timeout = tim_q > TMO;

  // Byte deserialiser: synchroniser, start validation, LSB-first sampling.
  always_comb begin
    sync_d  = {sync_q[1:0], bus.rxd};
    bst_d   = bst_q;
    cnt_d   = cnt_q;
    bidx_d  = bidx_q;
    sh_d    = sh_q;
    rbyte_d = rbyte_q;
    bv_d    = 1'b0;
    fb_d    = 1'b0;
    case (bst_q)
      B_IDLE: begin
        if (fall) begin
          bst_d = B_START;
          cnt_d = '0;
        end
      end
      B_START: begin
        if (cnt_q == HALF_END) begin
          cnt_d  = '0;
          bidx_d = '0;
          bst_d  = rx_s ? B_IDLE : B_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      B_DATA: begin
        if (cnt_q == BIT_END) begin
          cnt_d  = '0;
          sh_d   = {rx_s, sh_q[7:1]};
          bidx_d = bidx_q + 3'd1;
          if (bidx_q == 3'd7) bst_d = B_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        if (cnt_q == BIT_END) begin
          cnt_d = '0;
          bst_d = B_IDLE;
          if (rx_s) begin
            bv_d    = 1'b1;
            rbyte_d = sh_q;
          end else begin
            fb_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  // Packet framer: hunt for sync, collect payload, verify checksum.
  always_comb begin
    pst_d    = pst_q;
    idx_d    = idx_q;
    sum_d    = sum_q;
    shadow_d = shadow_q;
    flags_d  = flags_q;
    tim_d    = tim_q;
    params_d = params_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    if (pst_q == P_HUNT) begin
      tim_d = '0;
      if (bv_q && rbyte_q == SYNC_BYTE) begin
        pst_d = P_PAY;
        idx_d = '0;
        sum_d = '0;
      end
    end else begin
      if (bv_q) tim_d = '0;
      else if (!timeout) tim_d = tim_q + 32'd1;
      if (fb_q || timeout) begin
        err_d = 1'b1;
        pst_d = P_HUNT;
      end else if (bv_q) begin
        if (pst_q == P_PAY) begin
          sum_d = sum_q + rbyte_q;
          idx_d = idx_q + 5'd1;
          if (idx_q == 5'd19) begin
            flags_d = rbyte_q[2:0];
            pst_d   = P_CHK;
          end else begin
            shadow_d = {shadow_q[143:0], rbyte_q};
          end
        end else begin
          pst_d = P_HUNT;
          if (rbyte_q == sum_q) begin
            params_d = {shadow_q, flags_q};
            done_d   = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
    end
  end

  // Byte-side state registers.
  always_ff @(posedge clk_pll) begin
    if (!reset) begin
      sync_q  <= 3'b111;
      bst_q   <= B_IDLE;
      cnt_q   <= '0;
      bidx_q  <= '0;
      sh_q    <= '0;
      rbyte_q <= '0;
      bv_q    <= 1'b0;
      fb_q    <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      bst_q   <= bst_d;
      cnt_q   <= cnt_d;
      bidx_q  <= bidx_d;
      sh_q    <= sh_d;
      rbyte_q <= rbyte_d;
      bv_q    <= bv_d;
      fb_q    <= fb_d;
    end
  end

  // Packet-side state and parameter output registers.
  always_ff @(posedge clk_pll) begin
    if (!reset) begin
      pst_q    <= P_HUNT;
      idx_q    <= '0;
      sum_q    <= '0;
      shadow_q <= '0;
      flags_q  <= '0;
      tim_q    <= '0;
      params_q <= DEF;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      pst_q    <= pst_d;
      idx_q    <= idx_d;
      sum_q    <= sum_d;
      shadow_q <= shadow_d;
      flags_q  <= flags_d;
      tim_q    <= tim_d;
      params_q <= params_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign bus.per      = params_q[154:147];
  assign bus.p1wid    = params_q[146:131];
  assign bus.del      = params_q[130:115];
  assign bus.p2wid    = params_q[114:99];
  assign bus.nut_w    = params_q[98:67];
  assign bus.nut_d    = params_q[66:35];
  assign bus.cp       = params_q[34:27];
  assign bus.p_bl     = params_q[26:19];
  assign bus.p_bl_off = params_q[18:3];
  assign bus.nut      = params_q[2];
  assign bus.bl       = params_q[1];
  assign bus.pu       = params_q[0];
  assign bus.rx_done  = done_q;
  assign bus.rx_err   = err_q;
endmodule
